// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes, chase direction,
// the default step period and the bar-graph thermometer encoder.
package led_seq_pkg;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_CHASE  = 2'd2;
   localparam logic [1:0] MODE_BAR    = 2'd3;

   // 10 Hz step rate from a 125 MHz clock (period minus one).
   localparam int unsigned DEFAULT_RATE_RESET = 12_499_999;

   // Widest bitmap bar_thermo can produce; callers cast down to their LED count.
   localparam int unsigned THERMO_MAX = 256;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // LED i lights when level exceeds i slices of 256/width each.
   function automatic logic [THERMO_MAX-1:0] bar_thermo(input logic [7:0]  level,
                                                       input int unsigned width);
      logic [THERMO_MAX-1:0] map;
      int unsigned           slice;
      map   = '0;
      slice = 256 / width;
      for (int unsigned i = 0; i < THERMO_MAX; i++) begin
         if ((i < width) && (32'(level) > i * slice)) map[i] = 1'b1;
      end
      return map;
   endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: a counter that wraps when it reaches rate_i and emits a
// one-cycle tick on the wrap cycle; clr_i restarts the count and masks the tick.
module led_prescaler #(
   parameter int unsigned RATE_WIDTH = 24
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   output logic                  tick_o
);

   logic [RATE_WIDTH-1:0] cnt;
   logic                  wrap;

   assign wrap   = (cnt == rate_i);
   assign tick_o = wrap & ~clr_i;

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt <= '0;
      end else if (clr_i || wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + RATE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: config shadows, per-step pattern state and a registered
// output mux driving the LED controller, with an alert flash overriding every mode.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned LED_WIDTH  = 8,
   parameter int unsigned RATE_WIDTH = 24,
   parameter int unsigned RATE_RESET = DEFAULT_RATE_RESET
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  cfg_we_i,
   input  logic [1:0]            mode_i,
   input  logic [LED_WIDTH-1:0]  pattern_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   input  logic [7:0]            level_i,
   input  logic                  alert_i,
   output logic [LED_WIDTH-1:0]  val_o,
   output logic                  step_o
);

   localparam int unsigned POS_W = $clog2(LED_WIDTH);

   typedef logic [LED_WIDTH-1:0] led_t;
   typedef logic [POS_W-1:0]     pos_t;

   localparam pos_t POS_TURN_HI = pos_t'(LED_WIDTH - 2);
   localparam pos_t POS_TURN_LO = pos_t'(1);

   logic [1:0]            mode_q;
   led_t                  pattern_q;
   logic [RATE_WIDTH-1:0] rate_q;

   logic       phase_q, phase_d;
   pos_t       pos_q,   pos_d;
   dir_e       dir_q,   dir_d;
   logic [7:0] bar_q,   bar_d;
   led_t       val_d;
   logic       tick;

   // A config write clears the prescaler, which also masks a coincident step.
   led_prescaler #(
      .RATE_WIDTH (RATE_WIDTH)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (cfg_we_i),
      .rate_i (rate_q),
      .tick_o (tick)
   );

   assign step_o = tick;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mode_q    <= MODE_STATIC;
         pattern_q <= '0;
         rate_q    <= RATE_WIDTH'(RATE_RESET);
      end else if (cfg_we_i) begin
         mode_q    <= mode_i;
         pattern_q <= pattern_i;
         rate_q    <= rate_i;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      phase_d = phase_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      bar_d   = bar_q;
      if (cfg_we_i) begin
         phase_d = 1'b0;
         pos_d   = '0;
         dir_d   = DIR_UP;
      end else if (tick) begin
         phase_d = ~phase_q;
         if (mode_q == MODE_CHASE) begin
            if (dir_q == DIR_UP) begin
               pos_d = pos_q + pos_t'(1);
               if (pos_q == POS_TURN_HI) dir_d = DIR_DOWN;
            end else begin
               pos_d = pos_q - pos_t'(1);
               if (pos_q == POS_TURN_LO) dir_d = DIR_UP;
            end
         end
         if (mode_q == MODE_BAR) bar_d = level_i;
      end
   end

   // Alert flashes with the step phase while the selected mode keeps running underneath.
   always_comb begin
      val_d = '0;
      if (alert_i) begin
         val_d = phase_q ? '1 : '0;
      end else begin
         case (mode_q)
            MODE_STATIC: val_d = pattern_q;
            MODE_BLINK:  val_d = phase_q ? '0 : pattern_q;
            MODE_CHASE:  val_d = led_t'(1) << pos_q;
            MODE_BAR:    val_d = led_t'(bar_thermo(bar_q, LED_WIDTH));
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         phase_q <= 1'b0;
         pos_q   <= '0;
         dir_q   <= DIR_UP;
         bar_q   <= '0;
         val_o   <= '0;
      end else begin
         phase_q <= phase_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         bar_q   <= bar_d;
         val_o   <= val_d;
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a step-count model predicts val_o/step_o each
// cycle into a queue; an independent monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_led_sequencer;
   import led_seq_pkg::*;

   localparam int W  = 8;
   localparam int RW = 24;
   localparam int RR = 19;   // short reset step period keeps the run brief

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          cfg_we_i;
   logic [1:0]    mode_i;
   logic [W-1:0]  pattern_i;
   logic [RW-1:0] rate_i;
   logic [7:0]    level_i;
   logic          alert_i;
   logic [W-1:0]  val_o;
   logic          step_o;

   always #5 clk_i = ~clk_i;

   led_sequencer #(
      .LED_WIDTH  (W),
      .RATE_WIDTH (RW),
      .RATE_RESET (RR)
   ) dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .cfg_we_i  (cfg_we_i),
      .mode_i    (mode_i),
      .pattern_i (pattern_i),
      .rate_i    (rate_i),
      .level_i   (level_i),
      .alert_i   (alert_i),
      .val_o     (val_o),
      .step_o    (step_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: everything derives from steps since the last config.
   int unsigned  m_mode, m_rate, m_cnt, m_steps;
   logic [W-1:0] m_pattern, m_val;
   logic [7:0]   m_bar;
   logic         m_step;

   typedef struct packed {
      logic [W-1:0] val;
      logic         step;
   } exp_t;

   exp_t sb[$];
   exp_t m_exp;

   function automatic logic [W-1:0] model_val(input logic alert);
      logic [W-1:0] v;
      int k, p;
      v = '0;
      if (alert) return (m_steps % 2 != 0) ? {W{1'b1}} : '0;
      case (m_mode)
         0: v = m_pattern;
         1: v = (m_steps % 2 != 0) ? '0 : m_pattern;
         2: begin
            k = int'(m_steps % (2 * (W - 1)));
            p = (k < W) ? k : 2 * (W - 1) - k;
            v[p] = 1'b1;
         end
         default: for (int i = 0; i < W; i++) v[i] = (int'(m_bar) > i * (256 / W));
      endcase
      return v;
   endfunction

   always @(negedge clk_i) begin
      if (!rstn_i) begin
         m_mode = 0; m_pattern = '0; m_rate = RR; m_cnt = 0;
         m_steps = 0; m_bar = '0; m_val = '0;
      end else begin
         m_step = !cfg_we_i && ((m_cnt % (m_rate + 1)) == m_rate);
         sb.push_back('{val: m_val, step: m_step});
         m_val = model_val(alert_i);
         if (cfg_we_i) begin
            m_mode = mode_i; m_pattern = pattern_i; m_rate = rate_i;
            m_cnt = 0; m_steps = 0;
         end else begin
            if (m_step) begin
               m_steps++;
               if (m_mode == 3) m_bar = level_i;
            end
            m_cnt++;
         end
      end
   end

   always @(negedge clk_i) begin
      #1;
      while (sb.size() > 0) begin
         m_exp = sb.pop_front();
         check("val_o", 32'(val_o), 32'(m_exp.val));
         check("step_o", 32'(step_o), 32'(m_exp.step));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Inputs are scrambled afterwards so the shadows must latch only on the strobe.
   task automatic do_cfg(input logic [1:0] m, input logic [W-1:0] p, input logic [RW-1:0] r);
      cfg_we_i = 1'b1; mode_i = m; pattern_i = p; rate_i = r;
      @(negedge clk_i); #1;
      check("cfg_step_mask", 32'(step_o), 32'd0);
      @(posedge clk_i); #1;
      cfg_we_i = 1'b0; mode_i = 2'($urandom); pattern_i = W'($urandom); rate_i = RW'($urandom);
   endtask

   logic [7:0] sweep [6];

   initial begin
      rstn_i = 1'b0; cfg_we_i = 1'b0; mode_i = '0; pattern_i = '0;
      rate_i = '0; level_i = '0; alert_i = 1'b0;
      sweep[0] = 8'd0;  sweep[1] = 8'd1;   sweep[2] = 8'd32;
      sweep[3] = 8'd33; sweep[4] = 8'd128; sweep[5] = 8'd255;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_val", 32'(val_o), 32'd0);
      check("reset_step", 32'(step_o), 32'd0);
      rstn_i = 1'b1;
      idle(3 * (RR + 1));

      do_cfg(MODE_STATIC, 8'hA5, 3);  idle(12);
      do_cfg(MODE_BLINK,  8'h0F, 1);  idle(12);
      do_cfg(MODE_CHASE,  8'h00, 0);  idle(30);

      do_cfg(MODE_BAR, 8'h00, 0);
      for (int i = 0; i < 6; i++) begin
         level_i = sweep[i];
         idle(1);
      end
      idle(2);

      do_cfg(MODE_CHASE, 8'h00, 2);
      idle(4);
      alert_i = 1'b1; idle(9);
      alert_i = 1'b0; idle(12);

      // Second config lands on the cycle the rate-2 prescaler would step.
      do_cfg(MODE_CHASE, 8'h00, 2);
      idle(2);
      do_cfg(MODE_CHASE, 8'h00, 2);
      idle(6);

      do_cfg(MODE_CHASE, 8'h00, 0);
      idle(6);
      check("chase_pos5", 32'(val_o), 32'h20);
      rstn_i = 1'b0;
      #1;
      check("async_reset_val", 32'(val_o), 32'd0);
      check("async_reset_step", 32'(step_o), 32'd0);
      idle(2);
      rstn_i = 1'b1;
      idle(2 * (RR + 1) + 2);

      for (int i = 0; i < 500; i++) begin
         level_i = 8'($urandom);
         if ($urandom_range(0, 9) == 0) alert_i = ~alert_i;
         if ($urandom_range(0, 29) == 0)
            do_cfg(2'($urandom), W'($urandom), RW'($urandom_range(0, 6)));
         else
            idle(1);
      end
      alert_i = 1'b0;
      idle(3);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Drives the 8-bit `val` input of the board LED controller, which turns each LED on for a high bit and off for a low bit.
- Sequences LED patterns from a programmable step rate. Modes: static, blink, bounce-chase and bar-graph.
- A status/alert override takes priority over all modes.
- Sits between the SPGD control/config registers and the LED controller.

Parameters:
- LED_WIDTH, 8, number of LEDs driven; must be ≥2.
- RATE_WIDTH, 24, width of the step-period register.
- RATE_RESET, 12499999, reset step period minus one (10 Hz at 125 MHz).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  single-cycle strobe; latches mode_i, pattern_i and rate_i into shadow registers.
- mode_i  in  2  0=STATIC, 1=BLINK, 2=CHASE, 3=BAR.
- pattern_i  in  LED_WIDTH  pattern used by STATIC and BLINK.
- rate_i  in  RATE_WIDTH  step period minus one, in clk_i cycles.
- level_i  in  8  unsigned bar-graph level; sampled live, used only on step.
- alert_i  in  1  override request, level-sensitive.
- val_o  out  LED_WIDTH  registered LED bitmap to the LED controller.
- step_o  out  1  one-cycle pulse per step.

Behaviour:
- Reset (async assert, sync release): the following hold until the first clock edge after rstn_i rises.
  - val_o=0, step_o=0.
  - mode_q=STATIC, pattern_q=0, rate_q=RATE_RESET.
  - cnt=0, phase=0, pos=0, dir=up, bar_q=0.
- Prescaler:
  - cnt increments every cycle.
  - When cnt==rate_q: cnt←0 and step_o=1 for that cycle.
  - rate_q=0 gives a step every cycle.
- Config:
  - On cfg_we_i: shadows load.
  - cnt←0, phase←0, pos←0, dir←up.
  - step_o is suppressed that cycle; cfg_we_i wins over a coincident step.
  - The new mode is visible on val_o 1 cycle later.
- State on step:
  - phase toggles.
  - CHASE:
    - if dir=up: pos++, and at pos==LED_WIDTH-2 dir←down.
    - if dir=down: pos--, and at pos==1 dir←up.
    - Sequence for 8 LEDs: 0,1,…,7,6,…,0,1… with no repeated endpoint.
  - BAR: bar_q←level_i.
- Output (registered, 1-cycle latency from state):
  - alert_i=1: val_o = phase ? all-ones : 0. Mode state keeps advancing underneath.
  - STATIC: val_o = pattern_q.
  - BLINK: val_o = phase ? 0 : pattern_q. The pattern is shown first after config.
  - CHASE: val_o = 1<<pos.
  - BAR: LED i lit iff bar_q > i*(256/LED_WIDTH).
    - level 0 → 0x00, level 1..32 → 0x01, level 255 → 0xFF (LED_WIDTH=8).
- Alert release: val_o returns to the current mode's output on the next cycle; there is no resync of phase/pos.
- Reset mid-sequence: all state returns to reset values immediately; no partial step.
- Mode values are all legal; no default path exists beyond reset.

Decomposition:
- Package led_seq_pkg:
  - Mode localparams MODE_STATIC/BLINK/CHASE/BAR (2-bit).
  - Default RATE_RESET.
  - Function bar_thermo(level, width) returning the thermometer bitmap.
- Sub-module led_prescaler:
  - Parameter RATE_WIDTH.
  - Inputs clk_i, rstn_i, clr_i, rate_i; output tick_o.
  - Contains the counter and compare.
- Top-level: shadow registers, phase/pos/dir state, output mux.

Test Plan:
- Reset with rstn_i low mid-CHASE (pos=5) → val_o=0x00 asynchronously; after release, STATIC/0x00 held and step_o pulses every 12500000 cycles.
- cfg mode=STATIC pattern=0xA5 rate=3 → val_o=0xA5 one cycle after cfg_we_i, unchanged across steps; step_o every 4 cycles.
- cfg BLINK pattern=0x0F rate=1 → val_o sequence 0x0F,0x0F,0x00,0x00,0x0F… (period 4 cycles).
- cfg CHASE rate=0 → val_o 0x01,0x02,…,0x80,0x40,…,0x01,0x02 on consecutive cycles; 0x80 and 0x01 each appear once per turn.
- cfg BAR rate=0, level_i sweep 0,1,32,33,128,255 → val_o 0x00,0x01,0x01,0x03,0x0F,0xFF.
- CHASE rate=2, alert_i high for 9 cycles then low → val_o toggles 0xFF/0x00 per step while high, then resumes chase at the advanced position; cfg_we_i coincident with a step → step_o=0 that cycle.
